// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: request side (start, a, b, bi)
// and response side (busy, done, diff, bo).
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bo;

  modport master (
    output start, a, b, bi,
    input  busy, done, diff, bo
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, diff, bo
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bi one bit per clock, LSB first,
// over WIDTH cycles, then presents diff/bo with a one-cycle done pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_subtractor_if.slave sub
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  logic bit_d;
  logic br_nxt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = busy_q;
    done_d  = done_q;
    diff_d  = diff_q;
    bo_d    = bo_q;

    bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    case (state_q)
      RUN: begin
        // Minuend register doubles as the result register: operand bits
        // leave at the LSB while difference bits enter at the MSB.
        a_d  = {bit_d, a_q[WIDTH-1:1]};
        b_d  = {1'b0, b_q[WIDTH-1:1]};
        br_d = br_nxt;
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {bit_d, a_q[WIDTH-1:1]};
          bo_d    = br_nxt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        if (sub.start) begin
          state_d = RUN;
          a_d     = sub.a;
          b_d     = sub.b;
          br_d    = sub.bi;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign sub.busy = busy_q;
  assign sub.done = done_q;
  assign sub.diff = diff_q;
  assign sub.bo   = bo_q;

endmodule
